// File: rtl/dmem_pkg.sv
// Shared types for the wait-state data memory.
// State encoding, default geometry and the access error check.
package dmem_pkg;

  localparam int DMEM_DEPTH = 32;
  localparam int IDX_W      = $clog2(DMEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Misaligned, beyond the array, or read+write together.
  function automatic logic dmem_addr_err(
    input logic [31:0] a,
    input logic        rd,
    input logic        wr,
    input int          iw
  );
    logic [31:0] hi;
    hi = a >> (iw + 2);
    return (a[1:0] != 2'b00) || (hi != '0) || (rd && wr);
  endfunction

endpackage

// File: rtl/data_mem_wait_wait_counter.sv
// 4-bit wait-state counter: load, decrement, zero flag.
// Ports: clk, rst, load_i/load_val_i, dec_i, zero_o.
module wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (dec_i && count_q != 4'd0)
      count_d = count_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= 4'd0;
    else     count_q <= count_d;
  end

  assign zero_o = (count_q == 4'd0);

endmodule

// File: rtl/data_mem_wait.sv
// Data memory answering after WAIT_STATES cycles with a mem_ready pulse.
// Ports: clk, rst, mem_read/mem_write/addr/write_data in; read_data/mem_ready/addr_err out.
module data_mem_wait
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1 << IDX_W,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        addr_err
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [31:0] mem [0:DEPTH-1];

  state_e      state_q, state_d;
  logic        rd_q, wr_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept, cnt_load, cnt_dec, cnt_zero;
  logic        finish;
  logic        cur_rd, cur_wr, err;
  logic [31:0] cur_addr, cur_wdata;
  logic [IW-1:0] idx;

  wait_counter u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (WS_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = DONE;
          end else begin
            state_d  = WAIT;
            cnt_load = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_zero) state_d = DONE;
        else          cnt_dec = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With no wait states the access completes on its acceptance
  // edge, so the live request is used instead of the latched copy.
  always_comb begin
    cur_rd    = (state_q == IDLE) ? mem_read   : rd_q;
    cur_wr    = (state_q == IDLE) ? mem_write  : wr_q;
    cur_addr  = (state_q == IDLE) ? addr       : addr_q;
    cur_wdata = (state_q == IDLE) ? write_data : wdata_q;
    finish    = (state_d == DONE);
    err       = dmem_addr_err(cur_addr, cur_rd, cur_wr, IW);
    idx       = cur_addr[IW+1:2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rd_q    <= mem_read;
        wr_q    <= mem_write;
        addr_q  <= addr;
        wdata_q <= write_data;
      end
      if (finish) begin
        err_q   <= err;
        rdata_q <= (!err && cur_rd) ? mem[idx] : 32'd0;
      end else begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  // Contents are never reset; a write commits only on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst && finish && !err && cur_wr)
      mem[idx] <= cur_wdata;
  end

  assign read_data = rdata_q;
  assign mem_ready = (state_q == DONE);
  assign addr_err  = err_q;

endmodule

// File: tb/tb_data_mem_wait.sv
// Testbench for data_mem_wait: vector table, scoreboard queue,
// reset-in-WAIT and zero-wait-state re-acceptance sequences.
module tb_data_mem_wait;

  localparam int WS = 2;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mem_read, mem_write;
  logic [31:0] addr, write_data, read_data;
  logic        mem_ready, addr_err;

  logic        rd0, wr0;
  logic [31:0] a0, wd0, rdata0;
  logic        rdy0, err0;

  data_mem_wait #(.DEPTH(32), .WAIT_STATES(WS)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .mem_ready  (mem_ready),
    .addr_err   (addr_err)
  );

  data_mem_wait #(.DEPTH(32), .WAIT_STATES(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (rd0),
    .mem_write  (wr0),
    .addr       (a0),
    .write_data (wd0),
    .read_data  (rdata0),
    .mem_ready  (rdy0),
    .addr_err   (err0)
  );

  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  logic [31:0] model [0:31];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fillv(input int i);
    return 32'hA500_0000 | 32'(i * 3);
  endfunction

  // One complete access on the WAIT_STATES=2 instance.
  task automatic access(input vec_t v, input string name,
                        input bit chk_lat);
    exp_t e, got;
    int n;
    @(negedge clk);
    mem_read   = v.rd;
    mem_write  = v.wr;
    addr       = v.a;
    write_data = v.wd;
    e.rd  = v.exp_rd;
    e.err = v.exp_err;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_ready && n < 40);
    if (!mem_ready) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: no mem_ready after %0d cycles", name, n);
      void'(sb.pop_front());
    end else begin
      got = sb.pop_front();
      check({name, " rdata"}, read_data, got.rd);
      check({name, " err"}, {31'd0, addr_err}, {31'd0, got.err});
      if (chk_lat) check({name, " latency"}, n, WS + 1);
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (v.wr && !v.exp_err) model[v.a[6:2]] = v.wd;
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (dut.mem[i] !== model[i]) bad++;
    check({name, " mem mismatches"}, bad, 0);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    addr = '0; write_data = '0;
    rd0 = 1'b0; wr0 = 1'b0; a0 = '0; wd0 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset ready", {31'd0, mem_ready}, 32'd0);
    check("reset rdata", read_data, 32'd0);
    check("reset err", {31'd0, addr_err}, 32'd0);

    for (int i = 0; i < 32; i++) begin
      v = '{1'b0, 1'b1, 32'(i * 4), fillv(i), 32'd0, 1'b0};
      access(v, "fill", 1'b0);
    end
    check_mem("fill");

    tbl.push_back('{0, 1, 32'h0C, 32'hDEAD_BEEF, 32'h0, 0});
    tbl.push_back('{1, 0, 32'h0C, 32'h0, 32'hDEAD_BEEF, 0});
    tbl.push_back('{0, 1, 32'h10, 32'h1234_5678, 32'h0, 0});
    tbl.push_back('{1, 0, 32'h10, 32'h0, 32'h1234_5678, 0});
    tbl.push_back('{1, 0, 32'h0E, 32'h0, 32'h0, 1});
    tbl.push_back('{0, 1, 32'h80, 32'hFFFF_FFFF, 32'h0, 1});
    tbl.push_back('{1, 1, 32'h04, 32'h5555_AAAA, 32'h0, 1});
    tbl.push_back('{1, 0, 32'h04, 32'h0, fillv(1), 0});
    tbl.push_back('{1, 0, 32'h7C, 32'h0, fillv(31), 0});
    tbl.push_back('{0, 1, 32'h7C, 32'hCAFE_F00D, 32'h0, 0});
    tbl.push_back('{1, 0, 32'h7C, 32'h0, 32'hCAFE_F00D, 0});
    tbl.push_back('{1, 0, 32'h8000_0000, 32'h0, 32'h0, 1});
    tbl.push_back('{0, 1, 32'h03, 32'h1111_1111, 32'h0, 1});
    foreach (tbl[i]) begin
      access(tbl[i], $sformatf("vec%0d", i), 1'b1);
      if (i == 3) check("mem[4]", dut.mem[4], 32'h1234_5678);
    end
    check_mem("after vectors");

    // Pulse is exactly one cycle.
    @(negedge clk);
    check("ready one cycle", {31'd0, mem_ready}, 32'd0);

    // Reset while a write waits: it must never commit.
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h08; write_data = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_write = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst ready", {31'd0, mem_ready}, 32'd0);
    check("rst rdata", read_data, 32'd0);
    check("rst err", {31'd0, addr_err}, 32'd0);
    begin
      int pulses;
      pulses = 0;
      repeat (5) begin
        @(negedge clk);
        if (mem_ready) pulses++;
      end
      check("rst no stale pulse", pulses, 0);
    end
    check("rst mem[2]", dut.mem[2], model[2]);
    v = '{1'b1, 1'b0, 32'h08, 32'h0, model[2], 1'b0};
    access(v, "post-rst read", 1'b1);

    // Zero wait states: a held read is re-accepted every other cycle.
    @(negedge clk);
    wr0 = 1'b1; a0 = 32'h0; wd0 = 32'h600D_0000;
    @(negedge clk);
    check("ws0 write ready", {31'd0, rdy0}, 32'd1);
    wr0 = 1'b0;
    @(negedge clk);
    rd0 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("ws0 ready c%0d", c), {31'd0, rdy0},
            {31'd0, (c % 2 == 0)});
      if (c % 2 == 0)
        check($sformatf("ws0 rdata c%0d", c), rdata0, 32'h600D_0000);
    end
    rd0 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
